// File: rtl/alpha_pkg.sv
// Shared types and default geometry for the alpha-blend sequencer, controller and arbiter.
package alpha_pkg;

  localparam int ADDR_W = 20;
  localparam int DIM_W  = 10;
  localparam int STRIDE = 640;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RD_SRC = 3'd1,
    WT_SRC = 3'd2,
    RD_DST = 3'd3,
    WT_DST = 3'd4,
    BLEND  = 3'd5,
    WR     = 3'd6,
    FIN    = 3'd7
  } alpha_seq_state_t;

endpackage

// File: rtl/alpha_sequencer_if.sv
// SRAM request/response port plus alpha-blend datapath strobes driven by the sequencer.
interface alpha_sequencer_if #(
  parameter int ADDR_W = alpha_pkg::ADDR_W
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_gnt;
  logic              mem_rvalid;
  logic              ld_src;
  logic              ld_dst;
  logic              blend_start;
  logic              blend_done;

  modport master (
    output mem_req, mem_we, mem_addr, ld_src, ld_dst, blend_start,
    input  mem_gnt, mem_rvalid, blend_done
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, ld_src, ld_dst, blend_start,
    output mem_gnt, mem_rvalid, blend_done
  );
endinterface

// File: rtl/alpha_addr_gen.sv
// Incremental x/y walker for the blend region; row bases step by STRIDE, pointers by one.
// Updates only on load/advance, so it never stalls the FSM.
module alpha_addr_gen #(
  parameter int ADDR_W = alpha_pkg::ADDR_W,
  parameter int DIM_W  = alpha_pkg::DIM_W,
  parameter int STRIDE = alpha_pkg::STRIDE
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              load,
  input  logic              advance,
  input  logic [ADDR_W-1:0] src_base,
  input  logic [ADDR_W-1:0] dst_base,
  input  logic [DIM_W-1:0]  width,
  input  logic [DIM_W-1:0]  height,
  output logic [ADDR_W-1:0] src_ptr,
  output logic [ADDR_W-1:0] dst_ptr,
  output logic              last_x,
  output logic              last_y
);
  import alpha_pkg::*;

  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(STRIDE);

  logic [ADDR_W-1:0] src_row, dst_row;
  logic [DIM_W-1:0]  x, y, w_r, h_r;

  assign last_x = (x == w_r - DIM_W'(1));
  assign last_y = (y == h_r - DIM_W'(1));

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      src_row <= '0;
      dst_row <= '0;
      src_ptr <= '0;
      dst_ptr <= '0;
      x       <= '0;
      y       <= '0;
      w_r     <= '0;
      h_r     <= '0;
    end else if (load) begin
      src_row <= src_base;
      dst_row <= dst_base;
      src_ptr <= src_base;
      dst_ptr <= dst_base;
      x       <= '0;
      y       <= '0;
      w_r     <= width;
      h_r     <= height;
    end else if (advance) begin
      if (!last_x) begin
        x       <= x + DIM_W'(1);
        src_ptr <= src_ptr + ADDR_W'(1);
        dst_ptr <= dst_ptr + ADDR_W'(1);
      end else begin
        // New row: pointers restart from the stepped row bases, not from the old pointers.
        x       <= '0;
        y       <= y + DIM_W'(1);
        src_row <= src_row + STEP;
        dst_row <= dst_row + STEP;
        src_ptr <= src_row + STEP;
        dst_ptr <= dst_row + STEP;
      end
    end
  end

endmodule

// File: rtl/alpha_sequencer.sv
// Per-pixel read-src / read-dst / blend / write-back sequencer; 7 cycles per pixel minimum.
// Requests hold address and direction until granted; each wait state stalls on its response.
module alpha_sequencer #(
  parameter int ADDR_W = alpha_pkg::ADDR_W,
  parameter int DIM_W  = alpha_pkg::DIM_W,
  parameter int STRIDE = alpha_pkg::STRIDE
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_base,
  input  logic [ADDR_W-1:0] dst_base,
  input  logic [DIM_W-1:0]  width,
  input  logic [DIM_W-1:0]  height,
  output logic              busy,
  output logic              done,
  alpha_sequencer_if.master bus
);
  import alpha_pkg::*;

  alpha_seq_state_t  st, nxt;
  logic              load, advance, last_x, last_y, blend_q;
  logic [ADDR_W-1:0] src_ptr, dst_ptr;

  alpha_addr_gen #(.ADDR_W(ADDR_W), .DIM_W(DIM_W), .STRIDE(STRIDE)) u_addr (
    .clk      (clk),
    .n_rst    (n_rst),
    .load     (load),
    .advance  (advance),
    .src_base (src_base),
    .dst_base (dst_base),
    .width    (width),
    .height   (height),
    .src_ptr  (src_ptr),
    .dst_ptr  (dst_ptr),
    .last_x   (last_x),
    .last_y   (last_y)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      st      <= IDLE;
      blend_q <= 1'b0;
    end else begin
      st      <= nxt;
      blend_q <= (st == WT_DST) && bus.mem_rvalid;
    end
  end

  always_comb begin
    nxt          = st;
    load         = 1'b0;
    advance      = 1'b0;
    bus.mem_req  = 1'b0;
    bus.mem_we   = 1'b0;
    bus.mem_addr = '0;
    bus.ld_src   = 1'b0;
    bus.ld_dst   = 1'b0;
    case (st)
      IDLE: begin
        if (start) begin
          load = 1'b1;
          nxt  = (width == '0 || height == '0) ? FIN : RD_SRC;
        end
      end
      RD_SRC: begin
        bus.mem_req  = 1'b1;
        bus.mem_addr = src_ptr;
        if (bus.mem_gnt) nxt = WT_SRC;
      end
      WT_SRC: begin
        bus.ld_src = bus.mem_rvalid;
        if (bus.mem_rvalid) nxt = RD_DST;
      end
      RD_DST: begin
        bus.mem_req  = 1'b1;
        bus.mem_addr = dst_ptr;
        if (bus.mem_gnt) nxt = WT_DST;
      end
      WT_DST: begin
        bus.ld_dst = bus.mem_rvalid;
        if (bus.mem_rvalid) nxt = BLEND;
      end
      BLEND: begin
        if (bus.blend_done) nxt = WR;
      end
      WR: begin
        bus.mem_req  = 1'b1;
        bus.mem_we   = 1'b1;
        bus.mem_addr = dst_ptr;
        if (bus.mem_gnt) begin
          if (last_x && last_y) begin
            nxt = FIN;
          end else begin
            advance = 1'b1;
            nxt     = RD_SRC;
          end
        end
      end
      FIN:     nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  assign bus.blend_start = blend_q;
  assign busy            = (st != IDLE) && (st != FIN);
  assign done            = (st == FIN);

endmodule

// File: doc/alpha_sequencer.md
Name: alpha_sequencer

Overview:
- Sequences the alpha-blend datapath over a rectangular region of the framebuffer.
- Per pixel: reads the source pixel, reads the destination pixel, triggers one blend, and writes the result back to the destination address.
- Sits between the command decoder (start/geometry) and the shared SRAM port plus the alpha blend unit.
- Addresses are generated incrementally, with no multiplier.

Parameters:
- ADDR_W, 20, framebuffer word-address width
- DIM_W, 10, width/height field width
- STRIDE, 640, pixels per framebuffer line (address delta per row)

Ports:
- clk  in  1  clock
- n_rst  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; latches geometry when idle
- src_base  in  ADDR_W  top-left source pixel address
- dst_base  in  ADDR_W  top-left destination pixel address
- width  in  DIM_W  region width in pixels
- height  in  DIM_W  region height in pixels
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse at end of region
- mem_req  out  1  memory request
- mem_we  out  1  1 = write, 0 = read; valid with mem_req
- mem_addr  out  ADDR_W  request address
- mem_gnt  in  1  request accepted this cycle
- mem_rvalid  in  1  read data valid; in-order, at least 1 cycle after gnt
- ld_src  out  1  datapath latches mem rdata as source pixel
- ld_dst  out  1  datapath latches mem rdata as destination pixel
- blend_start  out  1  one-cycle pulse to the blend unit
- blend_done  in  1  blend result valid; drives write data

Behaviour:
- Reset values: all outputs 0; state IDLE; counters and address registers 0.
- Reset asserted mid-operation aborts immediately to IDLE with no done pulse.
- States: IDLE, RD_SRC, WT_SRC, RD_DST, WT_DST, BLEND, WR, FIN.
- IDLE:
  - On start, latch src_base/dst_base into row and pixel address registers; latch width/height; x = y = 0.
  - If width==0 or height==0, go to FIN; otherwise go to RD_SRC.
  - start is ignored in every state other than IDLE.
- RD_SRC: mem_req=1, mem_we=0, mem_addr=src_ptr. Hold until mem_gnt, then go to WT_SRC.
- WT_SRC: ld_src = mem_rvalid. On mem_rvalid go to RD_DST.
- RD_DST: mem_req=1, mem_we=0, mem_addr=dst_ptr. On mem_gnt go to WT_DST.
- WT_DST: ld_dst = mem_rvalid. On mem_rvalid go to BLEND and assert blend_start for exactly that one transition cycle (registered pulse in the first BLEND cycle).
- BLEND: wait for blend_done, then go to WR.
- WR: mem_req=1, mem_we=1, mem_addr=dst_ptr. On mem_gnt, advance and branch:
  - x < width-1: x++, src_ptr++, dst_ptr++; go to RD_SRC.
  - x == width-1 and y < height-1: x=0, y++; src_row += STRIDE; dst_row += STRIDE; pointers reload from the new rows; go to RD_SRC.
  - x == width-1 and y == height-1: go to FIN.
- FIN: done=1 for one cycle, busy=0, then go to IDLE.
- Request hold rule:
  - mem_req, mem_we and mem_addr stay stable while mem_req=1 and mem_gnt=0.
  - mem_req deasserts in the cycle after gnt.
  - gnt when mem_req=0 is ignored.
- mem_rvalid outside WT_SRC/WT_DST is ignored; no ld_* strobe is produced.
- blend_done outside BLEND is ignored.
- busy=1 in every state except IDLE and FIN.
- Address arithmetic is modulo 2^ADDR_W; wrap is silent.
- Counters are DIM_W bits; width and height up to 2^DIM_W-1.
- Minimum per-pixel latency with gnt same-cycle, rvalid 1 cycle later and blend_done 1 cycle after blend_start: 7 cycles.

Decomposition:
- Package alpha_pkg holds:
  - the state enum alpha_seq_state_t (3 bits);
  - default ADDR_W, DIM_W and STRIDE localparams, shared with alpha_controller and the memory arbiter.
- One sub-module, alpha_addr_gen, holds:
  - x/y counters, row-base and pointer registers;
  - the inputs load, advance and the last_x/last_y flags.
- The FSM stays in alpha_sequencer.

Test Plan:
- 1x1 region, src_base=0x00100, dst_base=0x20000, gnt same-cycle, rvalid +1, blend_done +1:
  - bus sequence: read 0x00100, read 0x20000, write 0x20000;
  - one blend_start; done 8 cycles after start; busy low afterwards.
- 3x2 region, STRIDE=640, src_base=0, dst_base=1000:
  - write addresses in order 1000, 1001, 1002, 1640, 1641, 1642;
  - exactly 6 blend_start pulses; a single done pulse.
- width=0, height=5: done one cycle after start; mem_req never asserted; busy low throughout.
- mem_gnt delayed 4 cycles on each request: mem_addr/mem_we stable during the stall; spurious rvalid during RD_DST produces no ld_dst.
- start pulsed again mid-region: ignored, and the region completes unchanged.
- n_rst asserted during BLEND of pixel 2 of 4: all outputs 0 next edge, no done.
  - A new start after release completes normally from x=y=0.
